forward_cell_link_arbiter: RTL

FORWARD_CELL_LINK_ARBITER -- requirements
Module: forward_cell_link_arbiter

---
 rtl/forward_cell_link_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/forward_cell_link_arbiter.sv
// Two-source round-robin arbiter for a packet stream link.
// A grant holds until a TLAST release or an idle timeout, and at least one IDLE cycle separates grants.
module forward_cell_link_arbiter #(
  parameter int unsigned MAX_PKTS = 4,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        S00_REQ,
  input  logic        S01_REQ,
  input  logic        S00_ARB_REQ_SUPPRESS,
  input  logic        S01_ARB_REQ_SUPPRESS,
  input  logic        XFER,
  input  logic        XFER_TLAST,
  output logic        GRANT00,
  output logic        GRANT01,
  output logic        TIMEOUT_STROBE,
  output logic [15:0] PKT_COUNT00,
  output logic [15:0] PKT_COUNT01
);

  typedef enum logic [1:0] {StIdle, StGnt00, StGnt01} state_e;

  localparam logic [3:0]  MaxPktsLast = 4'(MAX_PKTS - 1);
  localparam logic [15:0] IdleLimit   = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 0: source 00, 1: source 01
  logic [3:0]  pkt_in_grant_q, pkt_in_grant_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] pkt_count00_q, pkt_count00_d;
  logic [15:0] pkt_count01_q, pkt_count01_d;
  logic        timeout_strobe_q, timeout_strobe_d;

  logic elig00, elig01, src_req, tlast_beat;

  assign elig00     = S00_REQ & ~S00_ARB_REQ_SUPPRESS;
  assign elig01     = S01_REQ & ~S01_ARB_REQ_SUPPRESS;
  assign src_req    = (state_q == StGnt00) ? S00_REQ : S01_REQ;
  assign tlast_beat = XFER & XFER_TLAST;

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    pkt_in_grant_d   = pkt_in_grant_q;
    idle_cnt_d       = idle_cnt_q;
    pkt_count00_d    = pkt_count00_q;
    pkt_count01_d    = pkt_count01_q;
    timeout_strobe_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Source 00 wins a tie only when source 01 was granted last.
        if (elig00 && (!elig01 || last_grant_q)) begin
          state_d        = StGnt00;
          last_grant_d   = 1'b0;
          pkt_in_grant_d = 4'd0;
          idle_cnt_d     = 16'd0;
        end else if (elig01) begin
          state_d        = StGnt01;
          last_grant_d   = 1'b1;
          pkt_in_grant_d = 4'd0;
          idle_cnt_d     = 16'd0;
        end
      end
      StGnt00, StGnt01: begin
        if (XFER) begin
          idle_cnt_d = 16'd0;
        end else if (idle_cnt_q == IdleLimit) begin
          state_d          = StIdle;
          timeout_strobe_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end

        if (tlast_beat) begin
          pkt_in_grant_d = pkt_in_grant_q + 4'd1;
          if (state_q == StGnt00) begin
            pkt_count00_d = pkt_count00_q + 16'd1;
          end else begin
            pkt_count01_d = pkt_count01_q + 16'd1;
          end
          if ((pkt_in_grant_q == MaxPktsLast) || !src_req) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q          <= StIdle;
      last_grant_q     <= 1'b1;
      pkt_in_grant_q   <= 4'd0;
      idle_cnt_q       <= 16'd0;
      pkt_count00_q    <= 16'd0;
      pkt_count01_q    <= 16'd0;
      timeout_strobe_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      pkt_in_grant_q   <= pkt_in_grant_d;
      idle_cnt_q       <= idle_cnt_d;
      pkt_count00_q    <= pkt_count00_d;
      pkt_count01_q    <= pkt_count01_d;
      timeout_strobe_q <= timeout_strobe_d;
    end
  end

  assign GRANT00        = (state_q == StGnt00);
  assign GRANT01        = (state_q == StGnt01);
  assign TIMEOUT_STROBE = timeout_strobe_q;
  assign PKT_COUNT00    = pkt_count00_q;
  assign PKT_COUNT01    = pkt_count01_q;

endmodule
